// File: rtl/prog_mem_loader.sv
// Instruction memory for the CPU fetch port, reloadable at run time from a host
// valid/ready stream; holds the CPU in reset while a new program is loaded.
module prog_mem_loader #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_n_rst,
  output logic [ADDR_W:0]   loaded_cnt,
  output logic              ovf
);

  localparam int DEPTH = 2 ** ADDR_W;
  // wptr is one bit wider than the address so it can sit at DEPTH without wrapping
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     wptr_q, wptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                cpu_n_rst_q, cpu_n_rst_d;
  logic                we_s;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Next-state, write-enable and counter updates
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    we_s    = 1'b0;
    case (state_q)
      RUN: begin
        if (ld_start) begin
          state_d = LOAD;
          wptr_d  = {(ADDR_W + 1){1'b0}};
          cnt_d   = {(ADDR_W + 1){1'b0}};
          ovf_d   = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (ld_start) begin
          // Restart: a word presented in the same cycle is dropped
          wptr_d = {(ADDR_W + 1){1'b0}};
          cnt_d  = {(ADDR_W + 1){1'b0}};
          ovf_d  = 1'b0;
        end else if (ld_valid) begin
          we_s   = 1'b1;
          wptr_d = wptr_q + (ADDR_W + 1)'(1);
          cnt_d  = cnt_q + (ADDR_W + 1)'(1);
          if (ld_last) begin
            state_d = RELEASE;
          end else if (wptr_q == LAST_IDX) begin
            state_d = RELEASE;
            ovf_d   = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      RELEASE: begin
        if (ld_start) begin
          state_d = LOAD;
          wptr_d  = {(ADDR_W + 1){1'b0}};
          cnt_d   = {(ADDR_W + 1){1'b0}};
          ovf_d   = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RELEASE;
      end
    endcase
    cpu_n_rst_d = (state_d == RUN);
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= RELEASE;
      wptr_q      <= {(ADDR_W + 1){1'b0}};
      cnt_q       <= {(ADDR_W + 1){1'b0}};
      ovf_q       <= 1'b0;
      cpu_n_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      cpu_n_rst_q <= cpu_n_rst_d;
    end
  end

  // Program storage; reset clears every word
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (we_s) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= ld_data;
    end
  end

  // Fetch is combinational: the CPU consumes data in the cycle it drives addr
  assign data       = mem_q[addr];
  assign ld_ready   = (state_q == LOAD);
  assign cpu_n_rst  = cpu_n_rst_q;
  assign loaded_cnt = cnt_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader with a 4-word x 4-bit memory.
module tb_prog_mem_loader;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              cpu_n_rst;
  logic [ADDR_W:0]   loaded_cnt;
  logic              ovf;

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] exp_mem [4];

  prog_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .n_rst(n_rst), .addr(addr), .data(data),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_n_rst(cpu_n_rst), .loaded_cnt(loaded_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 4'h0; ld_last = 1'b0; addr = 2'd0;
    tick();
    tick();
    n_rst = 1'b1;
    vectors++;
    if (cpu_n_rst !== 1'b0) begin $display("FAIL rst_cpu_n_rst_first got=%b exp=0", cpu_n_rst); miscompares++; end
    vectors++;
    if (ld_ready !== 1'b0) begin $display("FAIL rst_ld_ready got=%b exp=0", ld_ready); miscompares++; end
    vectors++;
    if (loaded_cnt !== 3'd0 || ovf !== 1'b0) begin
      $display("FAIL rst_cnt_ovf got=%0d/%b exp=0/0", loaded_cnt, ovf); miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      addr = 2'(i);
      #1;
      vectors++;
      if (data !== 4'h0) begin $display("FAIL rst_mem[%0d] got=%h exp=0", i, data); miscompares++; end
    end
    tick();
    vectors++;
    if (cpu_n_rst !== 1'b1) begin $display("FAIL rst_cpu_n_rst_second got=%b exp=1", cpu_n_rst); miscompares++; end
  endtask

  task automatic test_basic_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    vectors++;
    if (cpu_n_rst !== 1'b0 || ld_ready !== 1'b1) begin
      $display("FAIL basic_enter_load got cpu_n_rst=%b ld_ready=%b exp=0/1", cpu_n_rst, ld_ready); miscompares++;
    end
    ld_valid = 1'b1; ld_data = 4'h1; ld_last = 1'b0;
    tick();
    vectors++;
    if (cpu_n_rst !== 1'b0 || loaded_cnt !== 3'd1) begin
      $display("FAIL basic_word0 got cpu_n_rst=%b cnt=%0d exp=0/1", cpu_n_rst, loaded_cnt); miscompares++;
    end
    ld_data = 4'h0; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    vectors++;
    if (cpu_n_rst !== 1'b0 || ld_ready !== 1'b0 || loaded_cnt !== 3'd2 || ovf !== 1'b0) begin
      $display("FAIL basic_release got cpu_n_rst=%b rdy=%b cnt=%0d ovf=%b exp=0/0/2/0",
               cpu_n_rst, ld_ready, loaded_cnt, ovf); miscompares++;
    end
    tick();
    vectors++;
    if (cpu_n_rst !== 1'b1) begin $display("FAIL basic_run got cpu_n_rst=%b exp=1", cpu_n_rst); miscompares++; end
    exp_mem[0] = 4'h1; exp_mem[1] = 4'h0; exp_mem[2] = 4'h0; exp_mem[3] = 4'h0;
    for (int i = 0; i < 4; i++) begin
      addr = 2'(i);
      #1;
      vectors++;
      if (data !== exp_mem[i]) begin $display("FAIL basic_mem[%0d] got=%h exp=%h", i, data, exp_mem[i]); miscompares++; end
    end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] words [4];
    words[0] = 4'hA; words[1] = 4'hB; words[2] = 4'hC; words[3] = 4'hD;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = words[i]; ld_last = 1'b0;
      vectors++;
      if (ld_ready !== 1'b1) begin $display("FAIL ovf_ready_w%0d got=%b exp=1", i, ld_ready); miscompares++; end
      tick();
    end
    ld_data = 4'hE;
    vectors++;
    if (ld_ready !== 1'b0) begin $display("FAIL ovf_ready_on_E got=%b exp=0", ld_ready); miscompares++; end
    vectors++;
    if (ovf !== 1'b1 || loaded_cnt !== 3'd4) begin
      $display("FAIL ovf_flag_cnt got ovf=%b cnt=%0d exp=1/4", ovf, loaded_cnt); miscompares++;
    end
    tick();
    tick();
    ld_valid = 1'b0;
    vectors++;
    if (cpu_n_rst !== 1'b1 || ovf !== 1'b1 || loaded_cnt !== 3'd4) begin
      $display("FAIL ovf_hold_run got cpu_n_rst=%b ovf=%b cnt=%0d exp=1/1/4", cpu_n_rst, ovf, loaded_cnt); miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      addr = 2'(i);
      #1;
      vectors++;
      if (data !== words[i]) begin $display("FAIL ovf_mem[%0d] got=%h exp=%h", i, data, words[i]); miscompares++; end
    end
  endtask

  task automatic test_gaps();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 4'h5; ld_last = 1'b0;
    tick();
    ld_valid = 1'b0; ld_data = 4'h6; ld_last = 1'b1;
    tick();
    vectors++;
    if (ld_ready !== 1'b1 || loaded_cnt !== 3'd1) begin
      $display("FAIL gap_idle got rdy=%b cnt=%0d exp=1/1", ld_ready, loaded_cnt); miscompares++;
    end
    ld_valid = 1'b1; ld_data = 4'h7; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    vectors++;
    if (loaded_cnt !== 3'd2 || ovf !== 1'b0 || ld_ready !== 1'b0) begin
      $display("FAIL gap_done got cnt=%0d ovf=%b rdy=%b exp=2/0/0", loaded_cnt, ovf, ld_ready); miscompares++;
    end
    tick();
    exp_mem[0] = 4'h5; exp_mem[1] = 4'h7; exp_mem[2] = 4'hC; exp_mem[3] = 4'hD;
    for (int i = 0; i < 4; i++) begin
      addr = 2'(i);
      #1;
      vectors++;
      if (data !== exp_mem[i]) begin $display("FAIL gap_mem[%0d] got=%h exp=%h", i, data, exp_mem[i]); miscompares++; end
    end
  endtask

  task automatic test_restart();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 4'h3; ld_last = 1'b0;
    tick();
    ld_start = 1'b1; ld_data = 4'h9;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0;
    addr = 2'd0;
    #1;
    vectors++;
    if (loaded_cnt !== 3'd0 || ld_ready !== 1'b1 || data !== 4'h3) begin
      $display("FAIL restart_discard got cnt=%0d rdy=%b mem0=%h exp=0/1/3", loaded_cnt, ld_ready, data); miscompares++;
    end
    addr = 2'd1;
    #1;
    vectors++;
    if (data !== 4'h7) begin $display("FAIL restart_mem1 got=%h exp=7", data); miscompares++; end
    ld_valid = 1'b1; ld_data = 4'h2; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    addr = 2'd0;
    #1;
    vectors++;
    if (data !== 4'h2 || loaded_cnt !== 3'd1) begin
      $display("FAIL restart_land0 got mem0=%h cnt=%0d exp=2/1", data, loaded_cnt); miscompares++;
    end
    addr = 2'd1;
    #1;
    vectors++;
    if (data !== 4'h7) begin $display("FAIL restart_keep1 got=%h exp=7", data); miscompares++; end
    tick();
  endtask

  task automatic test_reset_mid_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 4'h4; ld_last = 1'b0;
    tick();
    ld_valid = 1'b0;
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    vectors++;
    if (cpu_n_rst !== 1'b0 || ld_ready !== 1'b0 || loaded_cnt !== 3'd0 || ovf !== 1'b0) begin
      $display("FAIL midrst_state got cpu_n_rst=%b rdy=%b cnt=%0d ovf=%b exp=0/0/0/0",
               cpu_n_rst, ld_ready, loaded_cnt, ovf); miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      addr = 2'(i);
      #1;
      vectors++;
      if (data !== 4'h0) begin $display("FAIL midrst_mem[%0d] got=%h exp=0", i, data); miscompares++; end
    end
    tick();
    vectors++;
    if (cpu_n_rst !== 1'b1) begin $display("FAIL midrst_release got=%b exp=1", cpu_n_rst); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_overflow();
    test_gaps();
    test_restart();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Instruction-memory responder for the CPU fetch interface: the CPU drives `addr`, and this block returns the instruction word on `data` in the same cycle.
- Contents are written at run time through a host-side valid/ready load port.
- While a load is in progress the block holds the CPU in reset through `cpu_n_rst`, then releases it so the new program starts from address 0.
- Sits between the board-level host/loader and the CPU's `addr`/`data` pins.

Parameters:
- ADDR_W, 1: CPU fetch address width; DEPTH = 2**ADDR_W words.
- DATA_W, 1: instruction word width; matches the CPU `data` input.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  synchronous active-low reset.
- addr  input  ADDR_W  CPU fetch address.
- data  output  DATA_W  instruction word at `addr`; combinational read of storage.
- ld_start  input  1  single-cycle pulse; begins a new load from word 0.
- ld_valid  input  1  host word valid.
- ld_data  input  DATA_W  host word.
- ld_last  input  1  qualifies the final word of a load; sampled with ld_valid.
- ld_ready  output  1  block accepts a word; combinational, equal to (state==LOAD).
- cpu_n_rst  output  1  registered, active-low reset to the CPU.
- loaded_cnt  output  ADDR_W+1  number of words written by the most recent load.
- ovf  output  1  sticky flag: memory filled before ld_last was seen.

Behaviour:
- Reset (n_rst=0 at a clock edge) sets all of the following:
  - all DEPTH words = 0;
  - state = RELEASE; cpu_n_rst = 0;
  - wptr = 0; loaded_cnt = 0; ovf = 0;
  - ld_ready = 0.
- Reset asserted mid-load aborts the load. Words already written are cleared to 0 by the reset.
- Read path: data = mem[addr], no latency, in every state. The CPU latches its accumulator from `data` in the same cycle it presents `addr`, so a registered read is not allowed.
- FSM states: RUN, LOAD, RELEASE.
- RUN:
  - cpu_n_rst = 1; ld_ready = 0.
  - ld_start -> LOAD. On that edge: wptr = 0, loaded_cnt = 0, ovf = 0, cpu_n_rst = 0.
- LOAD:
  - cpu_n_rst = 0; ld_ready = 1.
  - A write fires when ld_valid=1 and ld_ready=1 and ld_start=0. It performs mem[wptr] <= ld_data, wptr += 1, loaded_cnt += 1.
  - If the write has ld_last=1 -> RELEASE.
  - Else if the write used wptr == DEPTH-1 -> RELEASE and ovf <= 1.
  - wptr never wraps. No word is written beyond DEPTH-1.
  - ld_start while in LOAD restarts the load: wptr = 0, loaded_cnt = 0, ovf = 0. Any word presented in that same cycle is discarded and not written.
  - Words not written by the current load keep their previous contents.
- RELEASE:
  - cpu_n_rst = 0 for exactly one cycle, then -> RUN. The CPU's first fetch after release is therefore at address 0.
  - ld_start in RELEASE -> LOAD, with the same initialisation as from RUN.
- ld_valid and ld_last outside LOAD are ignored. ld_valid may stay high across cycles; each cycle with the handshake true writes one word.
- loaded_cnt and ovf hold their values in RUN until the next ld_start or reset.

Test Plan:
1. Reset release (defaults): hold n_rst=0 for 2 cycles, then release.
   -> cpu_n_rst=0 in the first cycle after release and 1 in the second; data=0 for addr 0 and 1.
2. Basic load (defaults): ld_start, then words 1 (ld_last=0) and 0 (ld_last=1) on consecutive cycles.
   -> mem={1,0}; loaded_cnt=2; ovf=0; cpu_n_rst low from the cycle after ld_start through the RELEASE cycle, then 1; addr=0 gives data=1.
3. Overflow (ADDR_W=2, DATA_W=4): load 5 words 0xA,0xB,0xC,0xD,0xE with no ld_last.
   -> mem={A,B,C,D}; loaded_cnt=4; ovf=1; ld_ready=0 when 0xE is presented; 0xE is never written.
4. Short load with backpressure gaps (ADDR_W=2, DATA_W=4): ld_valid toggles 1,0,1 and the second word carries ld_last.
   -> exactly 2 writes; words 2 and 3 keep their old values; loaded_cnt=2.
5. Restart collision (ADDR_W=2): write word 0x3, then assert ld_start together with ld_valid and ld_data=0x9.
   -> 0x9 is discarded; wptr=0; loaded_cnt=0; the next accepted word lands at address 0.
6. Reset during LOAD after 1 word: n_rst=0.
   -> state=RELEASE; all words 0; loaded_cnt=0; ovf=0; cpu_n_rst stays 0 and then goes to 1 after one RELEASE cycle.
